// File: rtl/ram_burst_master.sv
// ============================================================================
// Module      : ram_burst_master
// Description : Burst initiator for a RAM8-style port (registered write,
//               combinational read). Executes 1..2**AW word write or read
//               bursts accepted over a valid/ready command channel. Write
//               words arrive on a stream; read words leave on a registered
//               stream with last-word qualification.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_master #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [AW-1:0]    cmd_len_i,
  // write data stream
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_data_i,
  // read data stream
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_last_o,
  // status
  output logic             busy_o,
  // RAM port
  output logic             ram_load_o,
  output logic [AW-1:0]    ram_address_o,
  output logic [WIDTH-1:0] ram_in_o,
  input  logic [WIDTH-1:0] ram_out_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      cur_addr_q, cur_addr_d;
  logic [AW-1:0]      remaining_q, remaining_d;
  // Set once the final word of a read burst has been fetched from the RAM;
  // the burst then only waits for that word to be accepted downstream.
  logic               fetched_q, fetched_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;

  logic               w_rd_accept;
  logic               w_fetch;

  assign w_rd_accept = rd_valid_q & rd_ready_i;
  // A new word may be loaded into the output register whenever it is empty
  // or being drained this cycle, so an unthrottled consumer sees one word
  // per clock.
  assign w_fetch     = (state_q == ST_READ) && !fetched_q && (!rd_valid_q || rd_ready_i);

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      fetched_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      fetched_q   <= fetched_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    fetched_d   = fetched_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    cmd_ready_o = 1'b0;
    wr_ready_o  = 1'b0;
    ram_load_o  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cur_addr_d  = cmd_addr_i;
          remaining_d = cmd_len_i;
          fetched_d   = 1'b0;
          state_d     = cmd_write_i ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        wr_ready_o = 1'b1;
        // The RAM is written only on a stream handshake, so a stalled
        // producer never causes a spurious write.
        ram_load_o = wr_valid_i;
        if (wr_valid_i) begin
          cur_addr_d = cur_addr_q + AW'(1);
          if (remaining_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            remaining_d = remaining_q - AW'(1);
          end
        end
      end

      ST_READ: begin
        if (w_fetch) begin
          rd_data_d  = ram_out_i;
          rd_valid_d = 1'b1;
          rd_last_d  = (remaining_q == '0);
          cur_addr_d = cur_addr_q + AW'(1);
          if (remaining_q == '0) begin
            fetched_d = 1'b1;
          end else begin
            remaining_d = remaining_q - AW'(1);
          end
        end else if (w_rd_accept) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end
        if (w_rd_accept && rd_last_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign ram_address_o = cur_addr_q;
  assign ram_in_o      = wr_data_i;
  assign rd_valid_o    = rd_valid_q;
  assign rd_last_o     = rd_last_q;
  assign rd_data_o     = rd_data_q;

endmodule

`default_nettype wire
